// File: rtl/digit_classifier_pkg.sv
// Shared sizing and FSM encoding for the template-matching digit classifier.
package digit_classifier_pkg;
    localparam int N_TEMPLATES = 10;
    localparam int DIM         = 11;
    localparam int PIX_W       = 8;
    localparam int SUM_W       = $clog2(DIM * DIM * (2 ** PIX_W - 1) + 1);
    localparam int ROW_SUM_W   = 12;
    localparam int SEL_W       = 4;
    localparam int ROW_W       = 4;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SETTLE  = 3'd1,
        ACCUM   = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;
endpackage

// File: rtl/digit_classifier_if.sv
// Classifier handshake plus the template-mux path (select out, diff array back).
interface digit_classifier_if;
    import digit_classifier_pkg::*;

    logic                 start;
    logic [PIX_W-1:0]     diff_pixel [DIM-1:0][DIM-1:0];
    logic [SEL_W-1:0]     tmpl_sel;
    logic                 busy;
    logic                 done;
    logic [SEL_W-1:0]     digit;
    logic [SUM_W-1:0]     score;

    modport master (
        input  start, diff_pixel,
        output tmpl_sel, busy, done, digit, score
    );

    modport slave (
        output start, diff_pixel,
        input  tmpl_sel, busy, done, digit, score
    );
endinterface

// File: rtl/digit_classifier_row_adder.sv
// Combinational sum of one diff-array row, zero-extended to the row-sum width.
module diff_row_adder
    import digit_classifier_pkg::*;
(
    input  logic [PIX_W-1:0]     pix [DIM-1:0],
    output logic [ROW_SUM_W-1:0] row_sum
);
    always_comb begin
        row_sum = '0;
        for (int i = 0; i < DIM; i++) begin
            row_sum = row_sum + ROW_SUM_W'(pix[i]);
        end
    end
endmodule

// File: rtl/digit_classifier.sv
// Scans all templates one row per cycle and reports the lowest-score digit.
//   state   | meaning
//   IDLE    | waiting for start
//   SETTLE  | one cycle for the external mux to follow tmpl_sel
//   ACCUM   | add one row of the current diff array per cycle
//   COMPARE | fold acc into running minimum, advance or finish
//   DONE    | done pulse cycle, busy drops on exit
module digit_classifier
    import digit_classifier_pkg::*;
(
    input  logic iCLK,
    input  logic iRST_N,
    digit_classifier_if.master bus
);
    state_t               state;
    logic [ROW_W-1:0]     row_cnt;
    logic [SEL_W-1:0]     tmpl_sel_r;
    logic [SUM_W-1:0]     acc;
    logic [SUM_W-1:0]     min_score;
    logic [SEL_W-1:0]     best;
    logic [SEL_W-1:0]     digit_r;
    logic [SUM_W-1:0]     score_r;
    logic                 busy_r;
    logic                 done_r;

    logic [PIX_W-1:0]     row_pix [DIM-1:0];
    logic [ROW_SUM_W-1:0] row_sum;
    logic                 better;
    logic                 last_tmpl;

    always_comb begin
        for (int c = 0; c < DIM; c++) begin
            row_pix[c] = bus.diff_pixel[row_cnt][c];
        end
    end

    diff_row_adder u_row_adder (
        .pix     (row_pix),
        .row_sum (row_sum)
    );

    // Strict compare keeps the lowest index on ties.
    assign better    = acc < min_score;
    assign last_tmpl = tmpl_sel_r == SEL_W'(N_TEMPLATES - 1);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state      <= IDLE;
            row_cnt    <= '0;
            tmpl_sel_r <= '0;
            acc        <= '0;
            min_score  <= '0;
            best       <= '0;
            digit_r    <= '0;
            score_r    <= '0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        tmpl_sel_r <= '0;
                        acc        <= '0;
                        min_score  <= '1;
                        busy_r     <= 1'b1;
                        state      <= SETTLE;
                    end
                end
                SETTLE: begin
                    row_cnt <= '0;
                    state   <= ACCUM;
                end
                ACCUM: begin
                    acc <= acc + SUM_W'(row_sum);
                    if (row_cnt == ROW_W'(DIM - 1)) begin
                        state <= COMPARE;
                    end else begin
                        row_cnt <= row_cnt + 1'b1;
                    end
                end
                COMPARE: begin
                    if (better) begin
                        min_score <= acc;
                        best      <= tmpl_sel_r;
                    end
                    // Result registers load here so digit/score are valid with done.
                    if (last_tmpl) begin
                        digit_r <= better ? tmpl_sel_r : best;
                        score_r <= better ? acc : min_score;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end else begin
                        tmpl_sel_r <= tmpl_sel_r + 1'b1;
                        acc        <= '0;
                        state      <= SETTLE;
                    end
                end
                DONE: begin
                    busy_r <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tmpl_sel = tmpl_sel_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.digit    = digit_r;
    assign bus.score    = score_r;
endmodule
